// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the FSM state encoding, the source-select enum and the default widths.
package uart_tx_sched_pkg;

  localparam int unsigned BYTE_W_DEF = 8;
  localparam int unsigned TO_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_RD  = 1'b1
  } src_t;

  function automatic src_t other_src(input src_t s);
    return (s == SRC_ALU) ? SRC_RD : SRC_ALU;
  endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// The pointer moves to the source that lost (or was not granted) after each grant.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_alu,
  input  logic req_rd,
  output logic grant_vld_c,
  output src_t grant_src_c
);

  src_t ptr;

  // Contention resolved by the pointer; a lone requester always wins.
  always_comb begin
    grant_src_c = SRC_ALU;
    if (req_alu && req_rd) begin
      grant_src_c = ptr;
    end else if (req_rd) begin
      grant_src_c = SRC_RD;
    end
    grant_vld_c = en && (req_alu || req_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= SRC_ALU;
    end else if (grant_vld_c) begin
      ptr <= other_src(grant_src_c);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules ALU results (two bytes) and register-read data (one byte) onto a
// UART transmitter, handshaking on its busy flag and aborting stalled frames.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_vld,
  input  logic [2*BYTE_W-1:0] alu_data,
  output logic                alu_ack,
  input  logic                rd_vld,
  input  logic [BYTE_W-1:0]   rd_data,
  output logic                rd_ack,
  input  logic                tx_busy,
  output logic                tx_d_vld,
  output logic [BYTE_W-1:0]   tx_p_data,
  output logic                sched_busy,
  output logic                to_err
);

  localparam int unsigned FRAME_W = 2 * BYTE_W;
  localparam int unsigned TO_W    = $clog2(TO_CYC + 1);

  state_t             state;
  logic [FRAME_W-1:0] shift_q;
  logic [1:0]         byte_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic               arb_en_c;
  logic               grant_vld_c;
  src_t               grant_src_c;
  logic [FRAME_W-1:0] grant_frame_c;
  logic               to_expire_c;

  // Grants happen only from IDLE with the transmitter free, never during reset.
  assign arb_en_c = rst && (state == IDLE) && !tx_busy;

  uart_tx_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (arb_en_c),
    .req_alu     (alu_vld),
    .req_rd      (rd_vld),
    .grant_vld_c (grant_vld_c),
    .grant_src_c (grant_src_c)
  );

  assign alu_ack   = grant_vld_c && (grant_src_c == SRC_ALU);
  assign rd_ack    = grant_vld_c && (grant_src_c == SRC_RD);
  assign tx_p_data = shift_q[BYTE_W-1:0];

  assign grant_frame_c = (grant_src_c == SRC_ALU) ? alu_data
                                                  : {{BYTE_W{1'b0}}, rd_data};

  // The pulse cycle and the current cycle both count as busy-low cycles.
  assign to_expire_c = (32'(to_cnt) + 32'd2) >= 32'(TO_CYC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      tx_d_vld   <= 1'b0;
      sched_busy <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      tx_d_vld <= 1'b0;
      to_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld_c) begin
            shift_q    <= grant_frame_c;
            byte_cnt   <= (grant_src_c == SRC_ALU) ? 2'd2 : 2'd1;
            tx_d_vld   <= 1'b1;
            sched_busy <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (to_expire_c) begin
            to_err     <= 1'b1;
            byte_cnt   <= '0;
            sched_busy <= 1'b0;
            state      <= IDLE;
          end else if (to_cnt != TO_W'(TO_CYC)) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            byte_cnt <= byte_cnt - 2'd1;
            shift_q  <= shift_q >> BYTE_W;
            if (byte_cnt > 2'd1) begin
              tx_d_vld <= 1'b1;
              state    <= ISSUE;
            end else begin
              sched_busy <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a randomized
// run scored against a request/byte-stream model with a behavioural transmitter.
module tb_uart_tx_sched;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TO_CYC = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                alu_vld;
  logic [2*BYTE_W-1:0] alu_data;
  logic                alu_ack;
  logic                rd_vld;
  logic [BYTE_W-1:0]   rd_data;
  logic                rd_ack;
  logic                tx_busy;
  logic                tx_d_vld;
  logic [BYTE_W-1:0]   tx_p_data;
  logic                sched_busy;
  logic                to_err;

  logic model_en;
  logic model_busy;
  logic force_busy;
  int   model_delay;
  int   model_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_busy = model_busy | force_busy;

  uart_tx_sched #(.BYTE_W(BYTE_W), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_vld    (alu_vld),
    .alu_data   (alu_data),
    .alu_ack    (alu_ack),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .tx_busy    (tx_busy),
    .tx_d_vld   (tx_d_vld),
    .tx_p_data  (tx_p_data),
    .sched_busy (sched_busy),
    .to_err     (to_err)
  );

  // Transmitter: busy rises model_delay cycles after a start pulse, lasts model_len cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_en && tx_d_vld) begin
        repeat (model_delay) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (model_len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    alu_vld = 1'b0;
    rd_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_vld = 1'b1;
    rd_vld = 1'b1;
    alu_data = 16'hFFFF;
    rd_data = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({alu_ack, rd_ack, tx_d_vld, sched_busy, to_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {alu_ack, rd_ack, tx_d_vld, sched_busy, to_err});
    end
    checks++;
    if (tx_p_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", tx_p_data);
    end
    alu_vld = 1'b0;
    rd_vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sched_busy, tx_d_vld} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got %b want 00", {sched_busy, tx_d_vld});
    end
  endtask

  task automatic test_alu_frame();
    int acks, busy_fall, sched_fall;
    logic prev_busy, seen_sb, ack_seen;
    logic [7:0] got[$];
    acks = 0; busy_fall = -1; sched_fall = -1; prev_busy = 1'b0; seen_sb = 1'b0;
    do_reset();
    model_en = 1'b1; model_delay = 2; model_len = 11;
    @(posedge clk); #1;
    alu_vld = 1'b1; alu_data = 16'hA55A;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      ack_seen = alu_ack;
      if (alu_ack) acks++;
      if (tx_d_vld) got.push_back(tx_p_data);
      if (prev_busy && !tx_busy) busy_fall = c;
      if (seen_sb && !sched_busy && sched_fall < 0) sched_fall = c;
      if (sched_busy) seen_sb = 1'b1;
      prev_busy = tx_busy;
      @(posedge clk); #1;
      if (ack_seen) alu_vld = 1'b0;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL alu_ack_count: got %0d want 1", acks);
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL alu_pulses: got %0d want 2", got.size());
    end else if ({got[0], got[1]} !== 16'h5AA5) begin
      errors++;
      $display("FAIL alu_bytes: got %h %h want 5a a5", got[0], got[1]);
    end
    checks++;
    if (busy_fall < 0 || sched_fall != busy_fall + 1) begin
      errors++;
      $display("FAIL alu_sched_busy_fall: got cycle %0d want %0d", sched_fall, busy_fall + 1);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [7:0] got[$];
    logic a_seen, r_seen;
    int alu_phase;
    alu_phase = 0;
    do_reset();
    model_en = 1'b1; model_delay = 1; model_len = 2;
    @(posedge clk); #1;
    alu_vld = 1'b1; alu_data = 16'h1234;
    rd_vld = 1'b1; rd_data = 8'h7E;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      a_seen = alu_ack; r_seen = rd_ack;
      if (a_seen && r_seen) begin
        checks++; errors++;
        $display("FAIL rr_double_ack: cycle %0d both acks high", c);
      end
      if (a_seen) order.push_back(0);
      if (r_seen) order.push_back(1);
      if (tx_d_vld) got.push_back(tx_p_data);
      @(posedge clk); #1;
      if (a_seen) begin
        if (alu_phase == 0) begin
          alu_data = 16'h5678;
          alu_phase = 1;
        end else begin
          alu_vld = 1'b0;
        end
      end
      if (r_seen) rd_vld = 1'b0;
    end
    checks++;
    if (order.size() != 3) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d want 3", order.size());
    end else if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      errors++;
      $display("FAIL rr_grant_order: got %0d %0d %0d want 0 1 0", order[0], order[1], order[2]);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL rr_byte_count: got %0d want 5", got.size());
    end else if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h34127E7856) begin
      errors++;
      $display("FAIL rr_bytes: got %h %h %h %h %h want 34 12 7e 78 56",
               got[0], got[1], got[2], got[3], got[4]);
    end
  endtask

  task automatic test_timeout();
    int t_vld, n_vld, t_err, n_err, acks;
    logic [7:0] byte_seen;
    logic sb_at_err, ack_seen;
    t_vld = -1; n_vld = 0; t_err = -1; n_err = 0; acks = 0;
    byte_seen = 8'h00; sb_at_err = 1'b1;
    do_reset();
    model_en = 1'b0;
    @(posedge clk); #1;
    rd_vld = 1'b1; rd_data = 8'h3C;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ack_seen = rd_ack;
      if (rd_ack) acks++;
      if (tx_d_vld) begin
        n_vld++;
        t_vld = c;
        byte_seen = tx_p_data;
      end
      if (to_err) begin
        n_err++;
        if (t_err < 0) begin
          t_err = c;
          sb_at_err = sched_busy;
        end
      end
      @(posedge clk); #1;
      if (ack_seen) rd_vld = 1'b0;
    end
    checks++;
    if (acks != 1 || n_vld != 1 || byte_seen !== 8'h3C) begin
      errors++;
      $display("FAIL to_issue: acks %0d pulses %0d byte %h want 1 1 3c", acks, n_vld, byte_seen);
    end
    checks++;
    if (n_err != 1) begin
      errors++;
      $display("FAIL to_err_count: got %0d want 1", n_err);
    end
    checks++;
    if (t_err - t_vld != int'(TO_CYC)) begin
      errors++;
      $display("FAIL to_err_delay: got %0d want %0d", t_err - t_vld, TO_CYC);
    end
    checks++;
    if (sb_at_err !== 1'b0) begin
      errors++;
      $display("FAIL to_return_idle: sched_busy %b want 0", sb_at_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acks;
    logic ok, ack_seen;
    logic [7:0] got[$];
    acks = 0;
    do_reset();
    model_en = 1'b1; model_delay = 2; model_len = 11;
    @(posedge clk); #1;
    alu_vld = 1'b1; alu_data = 16'hBEEF;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (tx_d_vld) ok = 1'b1;
    end
    checks++;
    if (!ok || tx_p_data !== 8'hEF) begin
      errors++;
      $display("FAIL mid_first_byte: seen %b byte %h want 1 ef", ok, tx_p_data);
    end
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || {alu_ack, rd_ack, tx_d_vld, sched_busy, to_err, tx_p_data} !== 13'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy_seen %b got %b want all 0", ok,
               {alu_ack, rd_ack, tx_d_vld, sched_busy, to_err, tx_p_data});
    end
    rst = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ack_seen = alu_ack;
      if (alu_ack) acks++;
      if (tx_d_vld) got.push_back(tx_p_data);
      @(posedge clk); #1;
      if (ack_seen) alu_vld = 1'b0;
    end
    checks++;
    if (acks != 1 || got.size() != 2) begin
      errors++;
      $display("FAIL mid_resend_count: acks %0d pulses %0d want 1 2", acks, got.size());
    end else if ({got[0], got[1]} !== 16'hEFBE) begin
      errors++;
      $display("FAIL mid_resend_bytes: got %h %h want ef be", got[0], got[1]);
    end
  endtask

  task automatic test_busy_hold();
    int bad;
    bad = 0;
    do_reset();
    model_en = 1'b0;
    force_busy = 1'b1;
    rd_vld = 1'b1; rd_data = 8'h81;
    repeat (6) begin
      @(negedge clk);
      if (rd_ack || alu_ack || tx_d_vld) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_no_grant: got %0d grant cycles want 0", bad);
    end
    force_busy = 1'b0;
    #1;
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL busy_release_ack: rd_ack %b want 1", rd_ack);
    end
    @(posedge clk); #1;
    rd_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_d_vld, tx_p_data} !== 9'h181) begin
      errors++;
      $display("FAIL busy_release_issue: got %b %h want 1 81", tx_d_vld, tx_p_data);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_final_idle: sched_busy %b want 0", sched_busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] alu_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  exp_q[$];
    logic        a_seen, r_seen, done;
    int          ptr;
    logic [7:0]  e;
    done = 1'b0;
    ptr = 0;
    for (int i = 0; i < 30; i++) begin
      alu_q.push_back(16'($urandom));
      rd_q.push_back(8'($urandom));
    end
    do_reset();
    model_en = 1'b1; model_delay = 2; model_len = 3;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      a_seen = alu_ack; r_seen = rd_ack;
      if (a_seen || r_seen) begin
        checks++;
        if ((a_seen && r_seen) || tx_busy) begin
          errors++;
          $display("FAIL rnd_ack_legal: acks %b%b busy %b", a_seen, r_seen, tx_busy);
        end
        if (alu_vld && rd_vld) begin
          checks++;
          if ((a_seen ? 0 : 1) != ptr) begin
            errors++;
            $display("FAIL rnd_rr_order: granted %0d want %0d", a_seen ? 0 : 1, ptr);
          end
        end
        if (a_seen) begin
          exp_q.push_back(alu_data[7:0]);
          exp_q.push_back(alu_data[15:8]);
          ptr = 1;
        end else begin
          exp_q.push_back(rd_data);
          ptr = 0;
        end
      end
      if (tx_d_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_byte: got %h want none", tx_p_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_p_data !== e) begin
            errors++;
            $display("FAIL rnd_byte: got %h want %h", tx_p_data, e);
          end
        end
        model_delay = int'($urandom_range(3, 1));
        model_len = int'($urandom_range(6, 1));
      end
      if (to_err) begin
        checks++; errors++;
        $display("FAIL rnd_unexpected_timeout: cycle %0d", c);
      end
      @(posedge clk); #1;
      if (a_seen) begin
        void'(alu_q.pop_front());
        alu_vld = 1'b0;
      end
      if (r_seen) begin
        void'(rd_q.pop_front());
        rd_vld = 1'b0;
      end
      if (!alu_vld && alu_q.size() > 0 && $urandom_range(3, 0) == 0) begin
        alu_vld = 1'b1;
        alu_data = alu_q[0];
      end
      if (!rd_vld && rd_q.size() > 0 && $urandom_range(3, 0) == 0) begin
        rd_vld = 1'b1;
        rd_data = rd_q[0];
      end
      done = (alu_q.size() == 0) && (rd_q.size() == 0) && !alu_vld && !rd_vld &&
             (exp_q.size() == 0) && !sched_busy && !tx_busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_drain: alu left %0d rd left %0d bytes left %0d",
               alu_q.size(), rd_q.size(), exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    alu_vld = 1'b0;
    alu_data = '0;
    rd_vld = 1'b0;
    rd_data = '0;
    force_busy = 1'b0;
    model_en = 1'b0;
    model_delay = 2;
    model_len = 3;
    test_reset();
    test_alu_frame();
    test_round_robin();
    test_timeout();
    test_reset_mid_frame();
    test_busy_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
